// File: rtl/nn_mem_pkg.sv
// Shared BRAM-side definitions for the layer output writer and the weight loaders:
// FSM state encodings and the BRAM read latency.
package nn_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_e;

  // Cycles from a read address on the BRAM port to its data on bram_dout.
  localparam int BRAM_RD_LAT = 2;

endpackage

// File: rtl/bram_addr_seq.sv
// Base-plus-offset BRAM address counter with load, increment and terminal-count flag.
// The address wraps modulo 2^ADDR_WIDTH; the count is one bit wider so it never wraps.
module bram_addr_seq #(
  parameter int ADDR_WIDTH = 18,
  parameter int BASE_ADDR  = 0,
  parameter int LAST_CNT   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   cnt,
  output logic                  last
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // load wins over inc so a caller can restart the sequence on its final step.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign addr = ADDR_WIDTH'(BASE_ADDR) + cnt_q[ADDR_WIDTH-1:0];
  assign last = (cnt_q == CW'(LAST_CNT));

endmodule

// File: rtl/layer_output_writer.sv
// Snapshots a flat bus of NUM_WORDS words on start and streams them into consecutive
// BRAM addresses from BASE_ADDR. Define WRITER_VERIFY_EN to add a read-back check pass.
module layer_output_writer
  import nn_mem_pkg::*;
#(
  parameter int NUM_WORDS  = 8,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int BASE_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_WORDS*W-1:0] data_in,
  output logic                   bram_en,
  output logic                   bram_wen,
  output logic                   bram_ren,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [W-1:0]           bram_din,
  input  logic [W-1:0]           bram_dout,
  output logic                   busy,
  output logic                   done,
  output logic                   verify_err,
  output logic [1:0]             state_dbg
);

  // Handshake: start is a level request taken only in IDLE; done stays high while start
  // is held, and start must drop (returning to IDLE) before another burst is accepted.

  localparam int CW = ADDR_WIDTH + 1;

  mem_state_e state_q, state_d;
  logic [NUM_WORDS*W-1:0] snap_q, snap_d;
  logic                   bram_en_q, bram_en_d;
  logic                   bram_wen_q, bram_wen_d;
  logic [ADDR_WIDTH-1:0]  bram_addr_q, bram_addr_d;
  logic [W-1:0]           bram_din_q, bram_din_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                  accept;
  logic                  rd_issue;
  logic                  seq_load, seq_inc, seq_last;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [CW-1:0]         seq_cnt;
  logic [W-1:0]          word_sel;

  bram_addr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .LAST_CNT   (NUM_WORDS - 1)
  ) u_addr_seq (
    .clk  (clk),
    .rst  (rst),
    .load (seq_load),
    .inc  (seq_inc),
    .addr (seq_addr),
    .cnt  (seq_cnt),
    .last (seq_last)
  );

  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (seq_cnt == CW'(k)) begin
        word_sel = snap_q[k*W +: W];
      end
    end
  end

`ifdef WRITER_VERIFY_EN
  // The verify pass keeps counting past the last read until the final compare lands.
  localparam logic [CW-1:0] VERIFY_END = CW'(NUM_WORDS - 1 + BRAM_RD_LAT);
  assign rd_issue = (state_q == ST_VERIFY) && (seq_cnt < CW'(NUM_WORDS));
`else
  assign rd_issue = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    seq_load = 1'b0;
    seq_inc  = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d   = data_in;
          seq_load = 1'b1;
          accept   = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        seq_inc = 1'b1;
        if (seq_last) begin
          seq_load = 1'b1;
`ifdef WRITER_VERIFY_EN
          state_d  = ST_VERIFY;
`else
          state_d  = ST_DONE;
`endif
        end
      end
`ifdef WRITER_VERIFY_EN
      ST_VERIFY: begin
        seq_inc = 1'b1;
        if (seq_cnt == VERIFY_END) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port outputs are registered one cycle behind the FSM state that produces them.
  always_comb begin
    bram_wen_d  = (state_q == ST_WRITE);
    bram_en_d   = bram_wen_d || rd_issue;
    bram_addr_d = bram_en_d ? seq_addr : bram_addr_q;
    bram_din_d  = bram_wen_d ? word_sel : bram_din_q;
    busy_d      = (state_d != ST_IDLE) && (state_q != ST_DONE);
    done_d      = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bram_en_q   <= 1'b0;
      bram_wen_q  <= 1'b0;
      bram_addr_q <= ADDR_WIDTH'(BASE_ADDR);
      bram_din_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bram_en_q   <= bram_en_d;
      bram_wen_q  <= bram_wen_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

`ifdef WRITER_VERIFY_EN
  logic                 bram_ren_q, bram_ren_d;
  logic [BRAM_RD_LAT:0] chk_vld_q, chk_vld_d;
  logic [W-1:0]         chk_exp_q [BRAM_RD_LAT+1];
  logic [W-1:0]         chk_exp_d [BRAM_RD_LAT+1];
  logic                 err_q, err_d;

  // Expected words ride alongside each read until its data returns on bram_dout.
  always_comb begin
    bram_ren_d   = rd_issue;
    chk_vld_d    = {chk_vld_q[BRAM_RD_LAT-1:0], rd_issue};
    chk_exp_d[0] = word_sel;
    for (int i = 1; i <= BRAM_RD_LAT; i++) begin
      chk_exp_d[i] = chk_exp_q[i-1];
    end
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (chk_vld_q[BRAM_RD_LAT] && (bram_dout != chk_exp_q[BRAM_RD_LAT])) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bram_ren_q <= 1'b0;
      chk_vld_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      bram_ren_q <= bram_ren_d;
      chk_vld_q  <= chk_vld_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    chk_exp_q <= chk_exp_d;
  end

  assign bram_ren   = bram_ren_q;
  assign verify_err = err_q;
`else
  logic unused_dout;
  assign unused_dout = ^{bram_dout, accept};
  assign bram_ren    = 1'b0;
  assign verify_err  = 1'b0;
`endif

  assign bram_en   = bram_en_q;
  assign bram_wen  = bram_wen_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
